// File: rtl/snake_collision_detector.sv
// Snake body store and collision scanner: one step per move_i; wall hit, self hit (one segment per cycle) or apple.
// Pulse length+1 cycles after move_i (1 cycle on a wall hit); no backpressure, moves outside RUN are dropped; `SNAKE_WRAP_EN wraps at edges.
module snake_collision_detector #(
  parameter int MAX_LEN   = 32,
  parameter int START_LEN = 3,
  parameter int START_X   = 8,
  parameter int START_Y   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         move_i,
  input  logic [1:0]                   dir_i,
  input  logic                         restart_i,
  input  logic [3:0]                   apple_x,
  input  logic [3:0]                   apple_y,
  output logic                         goodColl,
  output logic                         badColl,
  output logic [3:0]                   head_x,
  output logic [3:0]                   head_y,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                         alive
);

  localparam int            LW       = $clog2(MAX_LEN + 1);
  localparam int            IW       = $clog2(MAX_LEN);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEN_INIT = LW'(START_LEN);
  localparam logic [LW-1:0] LEN_ONE  = LW'(1);
  localparam logic [1:0]    DIR_UP    = 2'b00;
  localparam logic [1:0]    DIR_RIGHT = 2'b01;
  localparam logic [1:0]    DIR_DOWN  = 2'b10;
  localparam logic [1:0]    DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {RUN, CHECK, COMMIT, DEAD} state_t;

  state_t        state_q, state_d;
  logic [3:0]    seg_x_q [MAX_LEN];
  logic [3:0]    seg_x_d [MAX_LEN];
  logic [3:0]    seg_y_q [MAX_LEN];
  logic [3:0]    seg_y_d [MAX_LEN];
  logic [LW-1:0] length_q, length_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0]    dir_q, dir_d;
  logic [3:0]    cand_x_q, cand_x_d;
  logic [3:0]    cand_y_q, cand_y_d;
  logic          wall_q, wall_d;
  logic          self_q, self_d;
  logic          load_init;

  logic [1:0]    step_dir;
  logic [3:0]    step_x, step_y;
  logic          off_grid;

  // A request for the exact reverse keeps the current heading.
  always_comb begin
    step_dir = (dir_i == {~dir_q[1], dir_q[0]}) ? dir_q : dir_i;
    step_x   = seg_x_q[0];
    step_y   = seg_y_q[0];
    case (step_dir)
      DIR_UP:    step_y = seg_y_q[0] - 4'd1;
      DIR_RIGHT: step_x = seg_x_q[0] + 4'd1;
      DIR_DOWN:  step_y = seg_y_q[0] + 4'd1;
      default:   step_x = seg_x_q[0] - 4'd1;
    endcase
`ifdef SNAKE_WRAP_EN
    off_grid = 1'b0;
`else
    off_grid = (step_dir == DIR_UP    && seg_y_q[0] == 4'd0)  ||
               (step_dir == DIR_RIGHT && seg_x_q[0] == 4'd15) ||
               (step_dir == DIR_DOWN  && seg_y_q[0] == 4'd15) ||
               (step_dir == DIR_LEFT  && seg_x_q[0] == 4'd0);
`endif
  end

  always_comb begin
    state_d   = state_q;
    seg_x_d   = seg_x_q;
    seg_y_d   = seg_y_q;
    length_d  = length_q;
    idx_d     = idx_q;
    dir_d     = dir_q;
    cand_x_d  = cand_x_q;
    cand_y_d  = cand_y_q;
    wall_d    = wall_q;
    self_d    = self_q;
    load_init = 1'b0;
    goodColl  = 1'b0;
    badColl   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (move_i) begin
          dir_d    = step_dir;
          cand_x_d = step_x;
          cand_y_d = step_y;
          wall_d   = off_grid;
          self_d   = 1'b0;
          idx_d    = '0;
          state_d  = off_grid ? COMMIT : CHECK;
        end
      end
      CHECK: begin
        if (cand_x_q == seg_x_q[idx_q] && cand_y_q == seg_y_q[idx_q]) begin
          self_d = 1'b1;
        end
        if (LW'(idx_q) == length_q - LEN_ONE) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      COMMIT: begin
        if (wall_q || self_q) begin
          badColl = 1'b1;
          state_d = DEAD;
        end else begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x_d[i] = seg_x_q[i-1];
            seg_y_d[i] = seg_y_q[i-1];
          end
          seg_x_d[0] = cand_x_q;
          seg_y_d[0] = cand_y_q;
          // Growing keeps the old tail, which the shift has already moved down.
          if (cand_x_q == apple_x && cand_y_q == apple_y) begin
            goodColl = 1'b1;
            if (length_q != LEN_MAX) begin
              length_d = length_q + LEN_ONE;
            end
          end
          state_d = RUN;
        end
      end
      DEAD: begin
        if (restart_i) begin
          load_init = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || load_init) begin
      state_q  <= RUN;
      length_q <= LEN_INIT;
      idx_q    <= '0;
      dir_q    <= DIR_RIGHT;
      cand_x_q <= 4'(START_X);
      cand_y_q <= 4'(START_Y);
      wall_q   <= 1'b0;
      self_q   <= 1'b0;
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x_q[k] <= (k < START_LEN) ? 4'(START_X - k) : 4'd0;
        seg_y_q[k] <= (k < START_LEN) ? 4'(START_Y) : 4'd0;
      end
    end else begin
      state_q  <= state_d;
      length_q <= length_d;
      idx_q    <= idx_d;
      dir_q    <= dir_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      wall_q   <= wall_d;
      self_q   <= self_d;
      seg_x_q  <= seg_x_d;
      seg_y_q  <= seg_y_d;
    end
  end

  assign head_x = seg_x_q[0];
  assign head_y = seg_y_q[0];
  assign length = length_q;
  assign alive  = (state_q != DEAD);

endmodule

// File: tb/tb_snake_collision_detector.sv
// Bench for snake_collision_detector: queue-based snake model checked every cycle, plus directed literal checks.
module tb_snake_collision_detector;

  localparam int TB_MAX = 6;
  localparam int LW     = $clog2(TB_MAX + 1);

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } cell_t;

  logic          clk;
  logic          rst;
  logic          move_i;
  logic [1:0]    dir_i;
  logic          restart_i;
  logic [3:0]    apple_x;
  logic [3:0]    apple_y;
  logic          goodColl;
  logic          badColl;
  logic [3:0]    head_x;
  logic [3:0]    head_y;
  logic [LW-1:0] length;
  logic          alive;

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en;

  snake_collision_detector #(
    .MAX_LEN  (TB_MAX),
    .START_LEN(3),
    .START_X  (8),
    .START_Y  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .move_i   (move_i),
    .dir_i    (dir_i),
    .restart_i(restart_i),
    .apple_x  (apple_x),
    .apple_y  (apple_y),
    .goodColl (goodColl),
    .badColl  (badColl),
    .head_x   (head_x),
    .head_y   (head_y),
    .length   (length),
    .alive    (alive)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: body as a queue of cells (head first), plus a countdown to the decision cycle.
  cell_t body[$];
  int    m_dir;
  logic  m_alive;
  int    m_wait;
  logic  m_commit;
  logic  m_fault;
  cell_t m_cand;

  task automatic m_init();
    body.delete();
    for (int k = 0; k < 3; k++) body.push_back(cell_t'({4'(8 - k), 4'd8}));
    m_dir    = 1;
    m_alive  = 1'b1;
    m_wait   = 0;
    m_commit = 1'b0;
    m_fault  = 1'b0;
  endtask

  always @(posedge clk) begin
    int nx, ny, d;
    logic off, grow;
    if (rst) begin
      m_init();
    end else if (m_commit) begin
      m_commit = 1'b0;
      if (m_fault) begin
        m_alive = 1'b0;
      end else begin
        grow = (m_cand == {apple_x, apple_y}) && (body.size() < TB_MAX);
        body.push_front(m_cand);
        if (!grow) void'(body.pop_back());
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_commit = 1'b1;
    end else if (!m_alive) begin
      if (restart_i) m_init();
    end else if (move_i) begin
      d = (int'(dir_i) == (m_dir ^ 2)) ? m_dir : int'(dir_i);
      m_dir = d;
      nx = int'(body[0].x);
      ny = int'(body[0].y);
      case (d)
        0: ny = ny - 1;
        1: nx = nx + 1;
        2: ny = ny + 1;
        default: nx = nx - 1;
      endcase
      off = (nx < 0) || (nx > 15) || (ny < 0) || (ny > 15);
`ifdef SNAKE_WRAP_EN
      nx = (nx + 16) % 16;
      ny = (ny + 16) % 16;
      off = 1'b0;
`endif
      m_cand = cell_t'({4'(nx), 4'(ny)});
      if (off) begin
        m_fault  = 1'b1;
        m_commit = 1'b1;
      end else begin
        m_fault = 1'b0;
        foreach (body[i]) if (body[i] == m_cand) m_fault = 1'b1;
        m_wait = body.size();
      end
    end
  end

  always @(negedge clk) begin
    logic [10+LW:0] exp_v, act_v;
    logic exp_good, exp_bad;
    if (chk_en) begin
      exp_good = m_commit && !m_fault && (m_cand == {apple_x, apple_y});
      exp_bad  = m_commit && m_fault;
      exp_v = {exp_good, exp_bad, body[0].x, body[0].y, LW'(body.size()), m_alive};
      act_v = {goodColl, badColl, head_x, head_y, length, alive};
      n_checks++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL cycle_compare t=%0t dut good=%0b bad=%0b head=(%0d,%0d) len=%0d alive=%0b expected good=%0b bad=%0b head=(%0d,%0d) len=%0d alive=%0b",
                    $time, goodColl, badColl, head_x, head_y, length, alive,
                    exp_good, exp_bad, body[0].x, body[0].y, body.size(), m_alive);
    end
  end

  task automatic lit(input string nm, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  task automatic drive(input logic mv, input logic [1:0] d, input logic rs, input logic rr);
    move_i    = mv;
    dir_i     = d;
    restart_i = rs;
    rst       = rr;
    @(posedge clk);
    #1;
    move_i    = 1'b0;
    restart_i = 1'b0;
    rst       = 1'b0;
  endtask

  // Issue a move, then idle n edges; returns inside the decision cycle.
  task automatic step_move(input logic [1:0] d, input int n);
    drive(1'b1, d, 1'b0, 1'b0);
    repeat (n) drive(1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic set_apple(input int x, input int y);
    apple_x = 4'(x);
    apple_y = 4'(y);
  endtask

  initial begin
    logic any_pulse;
    chk_en = 1'b0;
    rst = 1'b1; move_i = 1'b0; dir_i = 2'd1; restart_i = 1'b0;
    set_apple(0, 0);
    drive(1'b0, 2'd1, 1'b0, 1'b1);
    chk_en = 1'b1;

    lit("reset_head_x", head_x, 8);
    lit("reset_head_y", head_y, 8);
    lit("reset_length", length, 3);
    lit("reset_alive", alive, 1);
    lit("reset_pulses", {goodColl, badColl}, 0);

    set_apple(9, 8);
    step_move(2'd1, 3);
    lit("eat_good", goodColl, 1);
    lit("eat_bad", badColl, 0);
    drive(1'b0, 2'd1, 1'b0, 1'b0);
    lit("eat_head_x", head_x, 9);
    lit("eat_length", length, 4);
    lit("eat_pulse_gone", goodColl, 0);

    set_apple(0, 0);
    step_move(2'd3, 4);
    lit("reverse_pulses", {goodColl, badColl}, 0);
    drive(1'b0, 2'd1, 1'b0, 1'b0);
    lit("reverse_head_x", head_x, 10);
    lit("reverse_head_y", head_y, 8);

    drive(1'b0, 2'd1, 1'b0, 1'b1);
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    drive(1'b0, 2'd1, 1'b0, 1'b1);
    lit("midscan_rst_head_x", head_x, 8);
    lit("midscan_rst_length", length, 3);
    lit("midscan_rst_alive", alive, 1);
    any_pulse = 1'b0;
    repeat (6) begin
      drive(1'b0, 2'd1, 1'b0, 1'b0);
      any_pulse = any_pulse | goodColl | badColl;
    end
    lit("midscan_rst_no_pulse", any_pulse, 0);
    lit("midscan_rst_no_step", head_x, 8);

    set_apple(9, 8);
    step_move(2'd1, 3);
    drive(1'b0, 2'd1, 1'b0, 1'b0);
    set_apple(10, 8);
    step_move(2'd1, 4);
    drive(1'b0, 2'd1, 1'b0, 1'b0);
    lit("grow_length5", length, 5);
    set_apple(0, 0);
    step_move(2'd0, 5);
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    step_move(2'd3, 5);
    drive(1'b0, 2'd3, 1'b0, 1'b0);
    lit("turn_head_x", head_x, 9);
    lit("turn_head_y", head_y, 7);
    set_apple(9, 8);
    step_move(2'd2, 5);
    lit("self_hit_bad", badColl, 1);
    lit("self_hit_on_apple_good", goodColl, 0);
    drive(1'b0, 2'd2, 1'b0, 1'b0);
    lit("self_hit_alive", alive, 0);
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    drive(1'b0, 2'd1, 1'b0, 1'b0);
    lit("dead_move_ignored_x", head_x, 9);
    lit("dead_move_ignored_y", head_y, 7);
    drive(1'b0, 2'd1, 1'b1, 1'b0);
    lit("restart_head_x", head_x, 8);
    lit("restart_head_y", head_y, 8);
    lit("restart_length", length, 3);
    lit("restart_alive", alive, 1);

    for (int ax = 9; ax <= 11; ax++) begin
      set_apple(ax, 8);
      step_move(2'd1, ax - 6);
      drive(1'b0, 2'd1, 1'b0, 1'b0);
    end
    lit("grow_length6", length, 6);
    set_apple(12, 8);
    step_move(2'd1, 6);
    lit("saturated_good", goodColl, 1);
    drive(1'b0, 2'd1, 1'b0, 1'b0);
    lit("saturated_length", length, 6);
    lit("saturated_head_x", head_x, 12);

    set_apple(0, 0);
    repeat (3) begin
      step_move(2'd1, 6);
      drive(1'b0, 2'd1, 1'b0, 1'b0);
    end
    lit("edge_head_x", head_x, 15);
`ifdef SNAKE_WRAP_EN
    step_move(2'd1, 6);
    lit("wrap_no_pulse", {goodColl, badColl}, 0);
    drive(1'b0, 2'd1, 1'b0, 1'b0);
    lit("wrap_head_x", head_x, 0);
    lit("wrap_alive", alive, 1);
`else
    step_move(2'd1, 0);
    lit("wall_bad", badColl, 1);
    lit("wall_good", goodColl, 0);
    drive(1'b0, 2'd1, 1'b0, 1'b0);
    lit("wall_alive", alive, 0);
    lit("wall_head_x", head_x, 15);
`endif
    drive(1'b0, 2'd1, 1'b0, 1'b1);

    for (int c = 0; c < 4000; c++) begin
      int ax, ay;
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 299) == 0));
      if ($urandom_range(0, 1) == 1) begin
        ax = int'(body[0].x) + $urandom_range(0, 2) - 1;
        ay = int'(body[0].y) + $urandom_range(0, 2) - 1;
        set_apple(ax & 15, ay & 15);
      end else begin
        set_apple($urandom_range(0, 15), $urandom_range(0, 15));
      end
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
